// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl_if
// Description : Bundle between the pipeline datapath and the stall/flush
//               controller: hazard sources from ID/EX, the data-memory
//               req/ack handshake, and the stage enable/flush controls.
//               master = pipeline side, slave = controller side.
//               Optional macro PIPE_HAZARD_CTRL_PERF_EN adds the performance
//               counter signals (stall_cycles, flush_events, bubble_events).
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_hazard_ctrl_if
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    #(parameter int CNT_W = 32)
`endif
    ();
    logic [4:0] id_rn;
    logic [4:0] id_rm;
    logic       id_uses_rn;
    logic       id_uses_rm;
    logic [4:0] ex_rd;
    logic       ex_reg_wr;
    logic       ex_mem_to_reg;
    logic       br_taken;
    logic       mem_req;
    logic       mem_ack;
    logic       pc_en;
    logic       ifid_en;
    logic       idex_en;
    logic       exmem_en;
    logic       memwb_en;
    logic       ifid_flush;
    logic       idex_flush;
    logic       memwb_flush;
    logic       mem_err;
    logic [1:0] ctrl_state;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;
    logic [CNT_W-1:0] bubble_events;
`endif

    modport master (
        output id_rn, id_rm, id_uses_rn, id_uses_rm, ex_rd, ex_reg_wr,
               ex_mem_to_reg, br_taken, mem_req, mem_ack,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush,
               idex_flush, memwb_flush, mem_err, ctrl_state
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        , input stall_cycles, flush_events, bubble_events
`endif
    );

    modport slave (
        input  id_rn, id_rm, id_uses_rn, id_uses_rm, ex_rd, ex_reg_wr,
               ex_mem_to_reg, br_taken, mem_req, mem_ack,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush,
               idex_flush, memwb_flush, mem_err, ctrl_state
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        , output stall_cycles, flush_events, bubble_events
`endif
    );
endinterface
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Stall/flush controller for the 5-stage pipeline. Resolves
//               memory wait states (req/ack with timeout), taken-branch
//               flushes and load-use bubbles, in that priority order.
// Ports       : clk - pipeline clock (rising edge)
//               rst - asynchronous active-low reset
//               hz  - pipe_hazard_ctrl_if.slave (hazard inputs, handshake,
//                     stage enables/flushes, mem_err, ctrl_state)
// Options     : PIPE_HAZARD_CTRL_PERF_EN - adds saturating stall/flush/bubble
//               counters on the interface.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int ZERO_REG    = 31
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    , parameter int CNT_W     = 32
`endif
) (
    input  wire logic       clk,
    input  wire logic       rst,
    pipe_hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1
    } state_t;

    localparam logic [4:0] c_ZERO_REG = ZERO_REG[4:0];
    localparam logic [7:0] c_TMO_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     r_state;
    logic [7:0] r_tmo_cnt;
    logic       r_mem_err;

    logic w_timeout;
    logic w_mem_stall;
    logic w_br_flush;
    logic w_ld_match;
    logic w_load_use;

    // The last allowed wait cycle is released as if ack had arrived, so the
    // access never stalls more than MEM_TIMEOUT cycles in total.
    assign w_timeout   = (r_state == ST_MEM_WAIT) && hz.mem_req && !hz.mem_ack &&
                         (r_tmo_cnt == c_TMO_LAST);
    // Gating with rst keeps every enable high while reset is held.
    assign w_mem_stall = rst && hz.mem_req && !hz.mem_ack && !w_timeout;
    assign w_br_flush  = rst && !w_mem_stall && hz.br_taken;

    assign w_ld_match  = hz.ex_mem_to_reg && hz.ex_reg_wr && (hz.ex_rd != c_ZERO_REG) &&
                         ((hz.id_uses_rn && (hz.id_rn == hz.ex_rd)) ||
                          (hz.id_uses_rm && (hz.id_rm == hz.ex_rd)));
    assign w_load_use  = rst && !w_mem_stall && !hz.br_taken && w_ld_match;

    always_comb begin
        hz.pc_en       = 1'b1;
        hz.ifid_en     = 1'b1;
        hz.idex_en     = 1'b1;
        hz.exmem_en    = 1'b1;
        hz.memwb_en    = 1'b1;
        hz.ifid_flush  = 1'b0;
        hz.idex_flush  = 1'b0;
        hz.memwb_flush = 1'b0;
        if (w_mem_stall) begin
            // Freeze IF..MEM; WB keeps draining and receives a bubble.
            hz.pc_en       = 1'b0;
            hz.ifid_en     = 1'b0;
            hz.idex_en     = 1'b0;
            hz.exmem_en    = 1'b0;
            hz.memwb_flush = 1'b1;
        end else if (w_br_flush) begin
            hz.ifid_flush = 1'b1;
            hz.idex_flush = 1'b1;
        end else if (w_load_use) begin
            // Hold PC and IF/ID one cycle; the load moves on and ID/EX
            // takes a single bubble.
            hz.pc_en      = 1'b0;
            hz.ifid_en    = 1'b0;
            hz.idex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_RUN;
            r_tmo_cnt <= 8'd0;
            r_mem_err <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    r_tmo_cnt <= 8'd0;
                    if (w_mem_stall) begin
                        r_state <= ST_MEM_WAIT;
                    end
                end
                ST_MEM_WAIT: begin
                    if (w_mem_stall) begin
                        r_tmo_cnt <= r_tmo_cnt + 8'd1;
                    end else begin
                        // ack, timeout or an illegal req drop all release.
                        r_state   <= ST_RUN;
                        r_tmo_cnt <= 8'd0;
                        if (w_timeout) begin
                            r_mem_err <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state   <= ST_RUN;
                    r_tmo_cnt <= 8'd0;
                end
            endcase
        end
    end

    assign hz.mem_err    = r_mem_err;
    assign hz.ctrl_state = r_state;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_flush_events;
    logic [CNT_W-1:0] r_bubble_events;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cycles  <= '0;
            r_flush_events  <= '0;
            r_bubble_events <= '0;
        end else begin
            if (w_mem_stall && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + 1'b1;
            end
            if (w_br_flush && (r_flush_events != '1)) begin
                r_flush_events <= r_flush_events + 1'b1;
            end
            if (w_load_use && (r_bubble_events != '1)) begin
                r_bubble_events <= r_bubble_events + 1'b1;
            end
        end
    end

    assign hz.stall_cycles  = r_stall_cycles;
    assign hz.flush_events  = r_flush_events;
    assign hz.bubble_events = r_bubble_events;
`endif
endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage pipeline. It drives the enables and flushes of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves three cases: load-use hazards, taken-branch flushes, and multi-cycle data-memory accesses that use a req/ack handshake. A small FSM with a timeout counter sequences memory wait states.

Parameters:
MEM_TIMEOUT, 16, max cycles held in MEM_WAIT before forced release (valid range 2..255).
ZERO_REG, 31, register index that never creates a hazard (XZR).
CNT_W, 32, width of the performance counters (optional feature only).

Ports:
clk  in  1  pipeline clock, rising edge
rst  in  1  asynchronous, active-low reset
id_rn  in  5  first source register of the instruction in ID
id_rm  in  5  second source register of the instruction in ID
id_uses_rn  in  1  ID instruction reads id_rn
id_uses_rm  in  1  ID instruction reads id_rm
ex_rd  in  5  destination register of the instruction in EX
ex_reg_wr  in  1  EX instruction writes a register
ex_mem_to_reg  in  1  EX instruction is a load
br_taken  in  1  EX resolved a taken branch this cycle
mem_req  in  1  instruction in MEM performs a data-memory access
mem_ack  in  1  data memory completes the access this cycle
pc_en  out  1  PC write enable
ifid_en  out  1  IF/ID enable
idex_en  out  1  ID/EX enable
exmem_en  out  1  EX/MEM enable
memwb_en  out  1  MEM/WB enable
ifid_flush  out  1  load NOP into IF/ID on next edge
idex_flush  out  1  load bubble (all control flags 0) into ID/EX on next edge
memwb_flush  out  1  load bubble into MEM/WB on next edge
mem_err  out  1  sticky flag: a memory access timed out
ctrl_state  out  2  current FSM state (debug)

Behaviour:
- Enable and flush outputs are combinational from the FSM state and the inputs. State, timeout counter and mem_err are registered.
- Reset (rst=0, asynchronous):
  - state=RUN, timeout counter=0, mem_err=0.
  - While reset is held: all enables=1, all flushes=0.
- FSM states: RUN=2'd0, MEM_WAIT=2'd1. Encodings 2'd2 and 2'd3 are illegal and must recover to RUN on the next edge.
- Memory stall condition: mem_req=1 and mem_ack=0.
  - This condition applies in RUN (transition to MEM_WAIT) and in MEM_WAIT (stay, increment counter).
  - While stalled: pc_en, ifid_en, idex_en, exmem_en = 0; memwb_en=1; memwb_flush=1. Stages hold and a bubble enters WB.
  - Zero-wait access (mem_req=1, mem_ack=1 in RUN): no stall, state stays RUN.
- MEM_WAIT exits:
  - mem_ack=1: go to RUN and clear the counter. Outputs that cycle are non-stalled, so the pipeline advances on that edge.
  - Counter reaches MEM_TIMEOUT-1 with no ack: set mem_err (sticky until reset). Release exactly as if ack had arrived.
  - mem_req deasserting in MEM_WAIT is illegal. Treat it as a release.
- Branch flush (br_taken=1, no memory stall): ifid_flush=1, idex_flush=1. All enables=1.
- Load-use (no memory stall, no branch flush): all of the following must hold.
  - ex_mem_to_reg=1 and ex_reg_wr=1 and ex_rd!=ZERO_REG.
  - Either (id_uses_rn and id_rn==ex_rd) or (id_uses_rm and id_rm==ex_rd).
  - Response: pc_en=0, ifid_en=0, idex_flush=1, other enables=1. This is exactly one bubble, because the load advances out of EX.
- Priority: memory stall > branch flush > load-use > normal.
  - A branch arriving during a stall stays asserted because EX is frozen. Its flush is applied in the release cycle.
  - On simultaneous branch and load-use, the flush wins and no bubble is counted.
- Normal: all enables=1, all flushes=0.
- Reset mid-stall: returns to RUN immediately and clears mem_err. No pending flush is remembered.

Optional Feature:
PIPE_HAZARD_CTRL_PERF_EN
- Defined: adds outputs stall_cycles, flush_events, bubble_events, each CNT_W bits, asynchronously reset to 0.
  - stall_cycles increments each memory-stall cycle.
  - flush_events increments each branch-flush cycle.
  - bubble_events increments each load-use bubble.
  - All counters saturate at all-ones.
- Undefined: these ports and counters do not exist. Remaining behaviour is identical.

Test Plan:
- Reset release → state=0, all enables=1, flushes=0, mem_err=0. Assert rst=0 during MEM_WAIT → outputs return to normal asynchronously.
- ex_rd=3, ex_mem_to_reg=1, ex_reg_wr=1, id_rn=3, id_uses_rn=1 → one cycle of pc_en=0, ifid_en=0, idex_flush=1. Repeat with ex_rd=31 → no stall.
- mem_req=1, mem_ack=0 for 4 cycles, then ack → state=1 for 4 cycles with pc_en, ifid_en, idex_en, exmem_en=0 and memwb_flush=1; on the ack cycle outputs are normal and state returns to 0.
- mem_req=1, never ack, MEM_TIMEOUT=16 → release after 16 stalled cycles, mem_err=1 and stays 1 through subsequent traffic.
- br_taken=1 together with a load-use match → ifid_flush=1, idex_flush=1, pc_en=1. br_taken during a 3-cycle memory stall → flushes asserted only in the release cycle.
- With PIPE_HAZARD_CTRL_PERF_EN defined: the above sequence → stall_cycles=4+16+3, flush_events and bubble_events match the counts of the stimulus applied.
